// File: rtl/miner_job_loader_if.sv
`default_nettype none
// ============================================================================
// Module : miner_job_loader_if
// Brief  : Byte links, job fields and core result bundle for miner_job_loader.
// Rev    : 1.0 - initial release
// ============================================================================
interface miner_job_loader_if;
    logic                rx_valid;
    logic [7:0]          rx_data;
    logic                rx_ready;
    logic                job_valid;
    logic [11:0][7:0]    job_data;
    logic [7:0][31:0]    job_state;
    logic [31:0]         job_nonce_base;
    logic [31:0][7:0]    job_target;
    logic                core_valid;
    logic [31:0]         core_nonce;
    logic                tx_valid;
    logic [7:0]          tx_data;
    logic                tx_ready;
    logic                busy;

    modport master (
        input  rx_valid, rx_data, core_valid, core_nonce, tx_ready,
        output rx_ready, job_valid, job_data, job_state, job_nonce_base,
               job_target, tx_valid, tx_data, busy
    );

    modport slave (
        output rx_valid, rx_data, core_valid, core_nonce, tx_ready,
        input  rx_ready, job_valid, job_data, job_state, job_nonce_base,
               job_target, tx_valid, tx_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/miner_job_loader.sv
`default_nettype none
// ============================================================================
// Module : miner_job_loader
// Brief  : Loads an 0xA5-framed 80-byte job, starts the search core and
//          returns a 5-byte status/nonce report over the tx byte link.
// Rev    : 1.0 - initial release
// ============================================================================
module miner_job_loader #(
    parameter int unsigned          TIMEOUT_W      = 32,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 32'hFFFF_FFFF
) (
    input  wire logic          clk,
    input  wire logic          rst,
    miner_job_loader_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_START  = 3'd2,
        S_RUN    = 3'd3,
        S_REPORT = 3'd4
    } state_t;

    localparam logic [7:0]           c_SYNC_BYTE    = 8'hA5;
    localparam logic [6:0]           c_LAST_IDX     = 7'd79;
    localparam logic [TIMEOUT_W-1:0] c_TIMEOUT_LAST = TIMEOUT_CYCLES - TIMEOUT_W'(1);
    localparam logic [TIMEOUT_W-1:0] c_BLANK_CYC    = TIMEOUT_W'(2);

    state_t                 r_state_q, w_state_d;
    logic [6:0]             r_idx_q, w_idx_d;
    logic [2:0]             r_byte_q, w_byte_d;
    logic [TIMEOUT_W-1:0]   r_cnt_q, w_cnt_d;
    logic [7:0]             r_status_q, w_status_d;
    logic [31:0]            r_nonce_q, w_nonce_d;
    logic                   r_job_valid_q, w_job_valid_d;
    logic                   r_busy_q, w_busy_d;
    logic                   r_tx_valid_q, w_tx_valid_d;
    logic [7:0]             r_tx_data_q, w_tx_data_d;
    logic [11:0][7:0]       r_job_data_q, w_job_data_d;
    logic [7:0][31:0]       r_job_state_q, w_job_state_d;
    logic [31:0]            r_job_nonce_q, w_job_nonce_d;
    logic [31:0][7:0]       r_job_target_q, w_job_target_d;

    logic                   w_rx_fire;
    logic [4:0]             w_tgt_idx;
    logic [7:0]             w_next_byte;

    assign bus.rx_ready = (r_state_q == S_IDLE) || (r_state_q == S_LOAD);
    assign w_rx_fire    = bus.rx_valid && bus.rx_ready;
    // Payload index 48..79 maps to target byte 79-i; modulo 32 that is 15-i.
    assign w_tgt_idx    = 5'd15 - r_idx_q[4:0];

    always_comb begin
        w_next_byte = r_nonce_q[7:0];
        case (r_byte_q)
            3'd0:    w_next_byte = r_nonce_q[31:24];
            3'd1:    w_next_byte = r_nonce_q[23:16];
            3'd2:    w_next_byte = r_nonce_q[15:8];
            default: w_next_byte = r_nonce_q[7:0];
        endcase
    end

    always_comb begin
        w_state_d      = r_state_q;
        w_idx_d        = r_idx_q;
        w_byte_d       = r_byte_q;
        w_cnt_d        = r_cnt_q;
        w_status_d     = r_status_q;
        w_nonce_d      = r_nonce_q;
        w_job_valid_d  = 1'b0;
        w_tx_valid_d   = r_tx_valid_q;
        w_tx_data_d    = r_tx_data_q;
        w_job_data_d   = r_job_data_q;
        w_job_state_d  = r_job_state_q;
        w_job_nonce_d  = r_job_nonce_q;
        w_job_target_d = r_job_target_q;

        case (r_state_q)
            S_IDLE: begin
                if (w_rx_fire && (bus.rx_data == c_SYNC_BYTE)) begin
                    w_state_d = S_LOAD;
                    w_idx_d   = 7'd0;
                end
            end
            S_LOAD: begin
                if (w_rx_fire) begin
                    if (r_idx_q < 7'd32) begin
                        w_job_state_d[r_idx_q[4:2]][{~r_idx_q[1:0], 3'b000} +: 8] = bus.rx_data;
                    end else if (r_idx_q < 7'd44) begin
                        w_job_data_d[r_idx_q[3:0]] = bus.rx_data;
                    end else if (r_idx_q < 7'd48) begin
                        w_job_nonce_d[{~r_idx_q[1:0], 3'b000} +: 8] = bus.rx_data;
                    end else begin
                        w_job_target_d[w_tgt_idx] = bus.rx_data;
                    end
                    if (r_idx_q == c_LAST_IDX) begin
                        w_state_d     = S_START;
                        w_job_valid_d = 1'b1;
                    end else begin
                        w_idx_d = r_idx_q + 7'd1;
                    end
                end
            end
            S_START: begin
                w_cnt_d   = '0;
                w_state_d = S_RUN;
            end
            S_RUN: begin
                w_cnt_d = r_cnt_q + TIMEOUT_W'(1);
                // Found is tested first so it wins over a coincident timeout.
                if ((r_cnt_q >= c_BLANK_CYC) && bus.core_valid) begin
                    w_status_d   = 8'h01;
                    w_nonce_d    = bus.core_nonce;
                    w_tx_data_d  = 8'h01;
                    w_tx_valid_d = 1'b1;
                    w_byte_d     = 3'd0;
                    w_state_d    = S_REPORT;
                end else if (r_cnt_q == c_TIMEOUT_LAST) begin
                    w_status_d   = 8'h00;
                    w_nonce_d    = 32'h0;
                    w_tx_data_d  = 8'h00;
                    w_tx_valid_d = 1'b1;
                    w_byte_d     = 3'd0;
                    w_state_d    = S_REPORT;
                end
            end
            S_REPORT: begin
                if (r_tx_valid_q && bus.tx_ready) begin
                    if (r_byte_q == 3'd4) begin
                        w_tx_valid_d = 1'b0;
                        w_tx_data_d  = 8'h00;
                        w_state_d    = S_IDLE;
                    end else begin
                        w_tx_data_d = w_next_byte;
                        w_byte_d    = r_byte_q + 3'd1;
                    end
                end
            end
            default: w_state_d = S_IDLE;
        endcase

        w_busy_d = (w_state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= S_IDLE;
            r_idx_q        <= '0;
            r_byte_q       <= '0;
            r_cnt_q        <= '0;
            r_status_q     <= '0;
            r_nonce_q      <= '0;
            r_job_valid_q  <= 1'b0;
            r_busy_q       <= 1'b0;
            r_tx_valid_q   <= 1'b0;
            r_tx_data_q    <= '0;
            r_job_data_q   <= '0;
            r_job_state_q  <= '0;
            r_job_nonce_q  <= '0;
            r_job_target_q <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_idx_q        <= w_idx_d;
            r_byte_q       <= w_byte_d;
            r_cnt_q        <= w_cnt_d;
            r_status_q     <= w_status_d;
            r_nonce_q      <= w_nonce_d;
            r_job_valid_q  <= w_job_valid_d;
            r_busy_q       <= w_busy_d;
            r_tx_valid_q   <= w_tx_valid_d;
            r_tx_data_q    <= w_tx_data_d;
            r_job_data_q   <= w_job_data_d;
            r_job_state_q  <= w_job_state_d;
            r_job_nonce_q  <= w_job_nonce_d;
            r_job_target_q <= w_job_target_d;
        end
    end

    assign bus.job_valid      = r_job_valid_q;
    assign bus.busy           = r_busy_q;
    assign bus.tx_valid       = r_tx_valid_q;
    assign bus.tx_data        = r_tx_data_q;
    assign bus.job_data       = r_job_data_q;
    assign bus.job_state      = r_job_state_q;
    assign bus.job_nonce_base = r_job_nonce_q;
    assign bus.job_target     = r_job_target_q;

endmodule
`default_nettype wire

// File: doc/miner_job_loader.md
# miner_job_loader

Byte-stream front end for the double-SHA256 nonce search core. It assembles an 81-byte job frame from a byte-serial link (UART/FIFO side) into the core's parallel job fields and fires a one-cycle start pulse. It then waits for the core's found indication or a cycle-count timeout, and returns a 5-byte report on a byte-serial transmit link. It sits directly upstream of the search core and also consumes its result outputs.

## Interface
Parameters:
- TIMEOUT_W, 32: width of the run timeout counter.
- TIMEOUT_CYCLES, 32'hFFFF_FFFF: number of RUN cycles after which the search is abandoned.

Ports:
- clk  in  1  the single clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_valid  in  1  receive byte valid.
- rx_data  in  8  receive byte.
- rx_ready  out  1  receive ready. A byte is accepted on a cycle where rx_valid && rx_ready.
- job_valid  out  1  one-cycle start pulse to the core's in_valid.
- job_data  out  [11:0][7:0]  header tail bytes, to the core's in_data.
- job_state  out  [7:0][31:0]  midstate, to the core's in_state.
- job_nonce_base  out  32  first nonce, to the core's in_nonce_base.
- job_target  out  [31:0][7:0]  target, to the core's in_target.
- core_valid  in  1  core out_valid; held high while the found result is latched.
- core_nonce  in  32  core out_nonce_found.
- tx_valid  out  1  transmit byte valid.
- tx_data  out  8  transmit byte.
- tx_ready  in  1  transmit ready. A byte is consumed on a cycle where tx_valid && tx_ready.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, LOAD, START, RUN, REPORT. Reset enters IDLE.
- IDLE:
  - rx_ready=1.
  - An accepted byte 0xA5 moves to LOAD with byte index 0.
  - Any other accepted byte is discarded and the FSM stays in IDLE (resync).
- LOAD:
  - rx_ready=1. Each accepted byte writes to payload index i (0..79), then i increments.
  - i 0..31 → job_state[i/4], big-endian within each word. Index 0 goes to job_state[0][31:24].
  - i 32..43 → job_data[i-32].
  - i 44..47 → job_nonce_base, MSB first.
  - i 48..79 → job_target[79-i]. The first target byte is job_target[31], the most significant byte.
  - A 0xA5 byte inside the payload is ordinary data, not a resync.
  - Acceptance of index 79 moves to START.
- START:
  - rx_ready=0, job_valid=1 for exactly this one cycle.
  - Clear the timeout counter and move to RUN.
- RUN:
  - rx_ready=0. The timeout counter increments every cycle.
  - core_valid is ignored for the first 2 RUN cycles (blanking for the core's registered output clear).
  - After blanking, the first cycle with core_valid=1 latches status=0x01 and nonce=core_nonce, then moves to REPORT.
  - If the counter equals TIMEOUT_CYCLES-1 without a find, latch status=0x00, nonce=0, and move to REPORT.
  - If core_valid and timeout coincide in the same cycle, found wins (status 0x01).
- REPORT:
  - Sends 5 bytes in order: status, nonce[31:24], nonce[23:16], nonce[15:8], nonce[7:0].
  - After the fifth handshake, go to IDLE.
- Job field registers are written only in LOAD. They hold their values through RUN and REPORT and until the next frame overwrites them.
- Reset during any state:
  - Return to IDLE.
  - All job fields go to 0. Any partial frame or pending report is dropped.

## Timing
- Reset values:
  - job_valid=0, tx_valid=0, tx_data=0, busy=0.
  - job_data, job_state, job_nonce_base, job_target all 0.
  - rx_ready=1 in the first cycle after rst deasserts.
- rx_ready is decoded from the state register only, never from rx_valid.
- job_valid rises on the clock edge after the 80th payload byte is accepted. All job fields are already stable in that cycle.
- Minimum frame-in to start latency: 82 cycles with rx_valid held high (81 bytes plus START).
- Found latency: REPORT is entered on the edge after the first qualifying core_valid cycle. tx_valid=1 with the status byte in that same REPORT cycle.
- tx_valid and tx_data are registered and held stable until the handshake. The next byte is presented on the cycle after the handshake. With tx_ready held high, the 5 bytes take 5 consecutive cycles.
- busy falls on the edge after the final tx handshake.

## Test plan
- Reset, then feed 0xA5, state bytes 0x00..0x1F, data 0x20..0x2B, nonce 0x12345678, target 0x00,0x00,0xFF×30 at one byte per cycle. Required:
  - job_valid is high for exactly 1 cycle, 82 cycles after the first byte.
  - job_state[0]=0x00010203, job_data[0]=0x20, job_nonce_base=0x12345678, job_target[31]=0x00, job_target[0]=0xFF.
- After the start pulse, raise core_valid with core_nonce=0xDEADBEEF on RUN cycle 10, tx_ready=1. Required: tx bytes 01, DE, AD, BE, EF on 5 consecutive cycles, then busy=0.
- TIMEOUT_CYCLES=16, core_valid held 0. Required: REPORT entered after 16 RUN cycles, with tx bytes 00 00 00 00 00.
- Timeout and core_valid asserted in the same cycle. Required: status byte 0x01.
- core_valid held high from before START (stale result). Required: it is ignored during the 2 blanking cycles. If it is still high on RUN cycle 3, a report of 0x01 is sent.
- Garbage bytes 0x11, 0x22 before 0xA5; tx_ready toggled 1/0 during REPORT; rst pulsed mid-LOAD. Required:
  - Garbage bytes are discarded.
  - tx_data is held while tx_ready=0.
  - After the reset, the FSM is in IDLE, job fields are 0, and a fresh full frame loads correctly.
